// File: rtl/board_judge.sv
// Move judge for a 4x4 drop game: checks legality, writes the piece, then scans
// the ten winning lines one per cycle to post win, draw or turn change.
module board_judge #(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter int   SCAN_LINES   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        drop_valid,
  input  logic [3:0]  drop_pos,
  output logic        busy,
  output logic        accepted,
  output logic        rejected,
  output logic        current_player,
  output logic [15:0] board_p1,
  output logic [15:0] board_p2,
  output logic [4:0]  move_count,
  output logic [1:0]  winner,
  output logic        game_over
);
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_t;

  state_t      state, state_nx;
  logic [3:0]  line_idx;
  logic [15:0] occ, mover_bd, mask, onehot;
  logic        legal, hit, last_line;
  logic        do_accept, do_reject, do_win, do_end;

  function automatic logic [15:0] line_mask(input logic [3:0] idx);
    case (idx)
      4'd0:    line_mask = 16'h000F;
      4'd1:    line_mask = 16'h00F0;
      4'd2:    line_mask = 16'h0F00;
      4'd3:    line_mask = 16'hF000;
      4'd4:    line_mask = 16'h1111;
      4'd5:    line_mask = 16'h2222;
      4'd6:    line_mask = 16'h4444;
      4'd7:    line_mask = 16'h8888;
      4'd8:    line_mask = 16'h8421;
      4'd9:    line_mask = 16'h1248;
      default: line_mask = 16'hFFFF;
    endcase
  endfunction

  assign occ       = board_p1 | board_p2;
  assign mover_bd  = current_player ? board_p2 : board_p1;
  assign mask      = line_mask(line_idx);
  assign hit       = (mover_bd & mask) == mask;
  assign last_line = line_idx == 4'(SCAN_LINES - 1);
  // A cell above row 0 needs support directly beneath it.
  assign legal     = !occ[drop_pos] && (drop_pos < 4'd4 || occ[drop_pos - 4'd4]);
  assign onehot    = 16'd1 << drop_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (new_game) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (drop_valid && legal) state_nx = CHECK;
        CHECK:   if (hit || (last_line && move_count == 5'd16)) state_nx = OVER;
                 else if (last_line) state_nx = IDLE;
        OVER:    state_nx = OVER;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == CHECK);
    do_accept = 1'b0;
    do_reject = 1'b0;
    do_win    = 1'b0;
    do_end    = 1'b0;
    if (!new_game) begin
      case (state)
        IDLE: begin
          do_accept = drop_valid && legal;
          do_reject = drop_valid && !legal;
        end
        CHECK: begin
          do_win = hit;
          do_end = !hit && last_line;
        end
        OVER:    do_reject = drop_valid;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_p1       <= '0;
      board_p2       <= '0;
      move_count     <= '0;
      winner         <= 2'b00;
      game_over      <= 1'b0;
      accepted       <= 1'b0;
      rejected       <= 1'b0;
      current_player <= FIRST_PLAYER;
      line_idx       <= '0;
    end else begin
      accepted <= do_accept;
      rejected <= do_reject;
      if (new_game) begin
        board_p1       <= '0;
        board_p2       <= '0;
        move_count     <= '0;
        winner         <= 2'b00;
        game_over      <= 1'b0;
        current_player <= FIRST_PLAYER;
        line_idx       <= '0;
      end else begin
        if (do_accept) begin
          if (current_player) board_p2 <= board_p2 | onehot;
          else                board_p1 <= board_p1 | onehot;
          if (move_count != 5'd16) move_count <= move_count + 5'd1;
          line_idx <= '0;
        end
        if (state == CHECK) line_idx <= line_idx + 4'd1;
        if (do_win) begin
          winner    <= current_player ? 2'b10 : 2'b01;
          game_over <= 1'b1;
        end
        if (do_end) begin
          if (move_count == 5'd16) begin
            winner    <= 2'b11;
            game_over <= 1'b1;
          end else begin
            current_player <= ~current_player;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_board_judge.sv
// Bench for board_judge: directed scenarios with literal expectations plus
// random play, all checked every cycle against a game-level reference model.
module tb_board_judge;
  logic        clk = 1'b0, rst = 1'b1, new_game = 1'b0, drop_valid = 1'b0;
  logic [3:0]  drop_pos = 4'd0;
  logic        busy, accepted, rejected, current_player, game_over;
  logic [15:0] board_p1, board_p2;
  logic [4:0]  move_count;
  logic [1:0]  winner;

  board_judge dut (
    .clk(clk), .rst(rst), .new_game(new_game), .drop_valid(drop_valid),
    .drop_pos(drop_pos), .busy(busy), .accepted(accepted), .rejected(rejected),
    .current_player(current_player), .board_p1(board_p1), .board_p2(board_p2),
    .move_count(move_count), .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  bit check_on = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game-level reference: cell sets per player, lines as lists of cells.
  int lines[10][4];
  int m_p1, m_p2, m_cnt, m_win, m_over, m_player, m_acc, m_rej, m_busy, m_timer, m_pend;

  initial begin
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) lines[r][c] = r*4 + c;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) lines[4+c][r] = r*4 + c;
    for (int i = 0; i < 4; i++) begin
      lines[8][i] = i*5;
      lines[9][i] = 3 + i*3;
    end
  end

  function automatic int first_win(input int bd);
    int all;
    for (int k = 0; k < 10; k++) begin
      all = 1;
      for (int j = 0; j < 4; j++) if (((bd >> lines[k][j]) & 1) == 0) all = 0;
      if (all == 1) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_cnt = 0; m_win = 0; m_over = 0; m_player = 0;
    m_acc = 0; m_rej = 0; m_busy = 0; m_timer = 0; m_pend = 0;
  endtask

  initial begin
    int p, occ, k;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        m_acc = 0; m_rej = 0;
        if (new_game) model_reset();
        else if (m_busy != 0) begin
          m_timer--;
          if (m_timer == 0) begin
            m_busy = 0;
            if (m_pend != 0) begin m_win = m_pend; m_over = 1; end
            else m_player ^= 1;
          end
        end else if (drop_valid) begin
          p = int'(drop_pos);
          occ = m_p1 | m_p2;
          if (m_over != 0 || ((occ >> p) & 1) == 1 || (p >= 4 && ((occ >> (p-4)) & 1) == 0))
            m_rej = 1;
          else begin
            if (m_player == 0) m_p1 |= (1 << p); else m_p2 |= (1 << p);
            m_cnt++; m_acc = 1; m_busy = 1;
            k = first_win(m_player == 0 ? m_p1 : m_p2);
            if (k >= 0) begin m_timer = k + 1; m_pend = m_player + 1; end
            else begin m_timer = 10; m_pend = (m_cnt == 16) ? 3 : 0; end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && check_on) begin
      chk("board_p1", int'(board_p1), m_p1);
      chk("board_p2", int'(board_p2), m_p2);
      chk("move_count", int'(move_count), m_cnt);
      chk("winner", int'(winner), m_win);
      chk("game_over", int'(game_over), m_over);
      chk("current_player", int'(current_player), m_player);
      chk("accepted", int'(accepted), m_acc);
      chk("rejected", int'(rejected), m_rej);
      chk("busy", int'(busy), m_busy);
    end
  end

  task automatic drop(input int p);
    @(negedge clk); drop_valid = 1'b1; drop_pos = 4'(p);
    @(negedge clk); drop_valid = 1'b0;
  endtask

  task automatic start_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 50) begin @(negedge clk); c++; end
    if (c >= 50) chk("idle_timeout", int'(busy), 0);
  endtask

  int draw_seq[16] = '{0,2,1,3,6,4,7,5,8,10,9,11,14,12,15,13};
  int win_seq[7]   = '{0,1,4,5,8,9,12};

  initial begin
    int c, col, h, occ;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_on = 1;
    @(negedge clk);
    chk("rst_board_p1", int'(board_p1), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_player", int'(current_player), 0);
    chk("rst_busy", int'(busy), 0);

    // single drop, full 10-cycle scan, turn passes
    drop(0);
    chk("t1_accepted", int'(accepted), 1);
    chk("t1_board_p1", int'(board_p1), 16'h0001);
    c = 0;
    while (busy && c < 40) begin c++; @(negedge clk); end
    chk("t1_busy_cycles", c, 10);
    chk("t1_player", int'(current_player), 1);

    // floating cell
    start_game();
    drop(4);
    chk("t2_rejected", int'(rejected), 1);
    chk("t2_count", int'(move_count), 0);
    chk("t2_player", int'(current_player), 0);

    // occupied cell
    start_game();
    drop(0); wait_idle();
    drop(0);
    chk("t3_rejected", int'(rejected), 1);
    chk("t3_board_p2", int'(board_p2), 0);

    // column-0 win for P1
    start_game();
    for (int i = 0; i < 6; i++) begin drop(win_seq[i]); wait_idle(); end
    drop(win_seq[6]);
    chk("t4_accepted", int'(accepted), 1);
    c = 0;
    while (!game_over && c < 40) begin @(negedge clk); c++; end
    chk("t4_latency", c, 5);
    chk("t4_winner", int'(winner), 1);
    drop(3);
    chk("t4_post_reject", int'(rejected), 1);

    // win-free full board
    start_game();
    for (int i = 0; i < 16; i++) begin drop(draw_seq[i]); wait_idle(); end
    chk("t5_winner", int'(winner), 3);
    chk("t5_game_over", int'(game_over), 1);
    chk("t5_count", int'(move_count), 16);

    // new_game mid-scan
    start_game();
    drop(0);
    @(negedge clk); @(negedge clk);
    new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    chk("t6_board_p1", int'(board_p1), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_accepted", int'(accepted), 0);

    // async reset mid-scan
    drop(1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("t6_rst_board_p1", int'(board_p1), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_count", int'(move_count), 0);
    @(negedge clk); #2 rst = 1'b0;

    // random play, mostly supported cells, occasional restarts
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      new_game = ($urandom % 150) == 0;
      drop_valid = ($urandom % 3) != 0;
      if (($urandom % 4) == 0) drop_pos = 4'($urandom % 16);
      else begin
        col = int'($urandom % 4);
        occ = m_p1 | m_p2;
        h = 0;
        while (h < 4 && ((occ >> (h*4 + col)) & 1) == 1) h++;
        drop_pos = 4'((h < 4) ? h*4 + col : col);
      end
    end
    @(negedge clk); new_game = 1'b0; drop_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
